// File: rtl/sea_battle_pkg.sv
// Shared constants, state encoding and grid index helper for the sea_battle game sequencer.
package sea_battle_pkg;

  localparam logic [1:0] CELL_EMPTY = 2'd0;
  localparam logic [1:0] CELL_SHIP  = 2'd1;
  localparam logic [1:0] CELL_MISS  = 2'd2;
  localparam logic [1:0] CELL_HIT   = 2'd3;

  localparam logic [2:0] KEY_UP    = 3'd0;
  localparam logic [2:0] KEY_DOWN  = 3'd1;
  localparam logic [2:0] KEY_LEFT  = 3'd2;
  localparam logic [2:0] KEY_RIGHT = 3'd3;
  localparam logic [2:0] KEY_FIRE  = 3'd4;

  localparam logic [3:0] GRID_N   = 4'd10;
  localparam logic [3:0] GRID_MAX = GRID_N - 4'd1;

  localparam logic BOARD_PLAYER = 1'b0;
  localparam logic BOARD_ENEMY  = 1'b1;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_P_WAIT,
    ST_P_READ,
    ST_P_WRITE,
    ST_CPU_THINK,
    ST_CPU_PICK,
    ST_C_READ,
    ST_C_WRITE,
    ST_OVER
  } state_e;

  // y*10+x without a multiplier; max 99 fits in 7 bits.
  function automatic logic [6:0] cell_index(input logic [3:0] y, input logic [3:0] x);
    return ({3'b000, y} << 3) + ({3'b000, y} << 1) + {3'b000, x};
  endfunction

endpackage

// File: rtl/sea_battle_lfsr8.sv
// 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1, used to pick computer shot coordinates.
module sea_battle_lfsr8 #(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic [7:0] lfsr
);

  logic [7:0] lfsr_q;
  logic [7:0] lfsr_d;

  // Next value: shift left, feedback from taps 8,6,5,4.
  always_comb begin
    lfsr_d = lfsr_q;
    if (en) begin
      lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end
  end

  // State register, seeded on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign lfsr = lfsr_q;

endmodule

// File: rtl/sea_battle_turn_ctrl.sv
// Game sequencer: cursor movement, player/computer shots and board RAM updates.
module sea_battle_turn_ctrl
  import sea_battle_pkg::*;
#(
  parameter int unsigned SHIP_CELLS = 20,
  parameter int unsigned CPU_DELAY  = 25000000,
  parameter logic [7:0]  LFSR_SEED  = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       key_valid,
  input  logic [2:0] key_code,
  output logic [3:0] cursor_x,
  output logic [3:0] cursor_y,
  output logic       turn,
  output logic       game_over,
  output logic       winner,
  output logic [4:0] player_hits,
  output logic [4:0] cpu_hits,
  output logic       mem_req,
  output logic       mem_we,
  output logic [7:0] mem_addr,
  output logic [1:0] mem_wdata,
  input  logic [1:0] mem_rdata,
  input  logic       mem_ack
);

  localparam int unsigned DW = (CPU_DELAY > 1) ? $clog2(CPU_DELAY + 1) : 1;
  localparam logic [DW-1:0] DELAY_L = DW'(CPU_DELAY);
  localparam logic [4:0]    SHIPS_L = 5'(SHIP_CELLS);

  state_e        state_q, state_d;
  logic [3:0]    cursor_x_q, cursor_x_d;
  logic [3:0]    cursor_y_q, cursor_y_d;
  logic          turn_q, turn_d;
  logic          game_over_q, game_over_d;
  logic          winner_q, winner_d;
  logic [4:0]    player_hits_q, player_hits_d;
  logic [4:0]    cpu_hits_q, cpu_hits_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic [7:0]    mem_addr_q, mem_addr_d;
  logic [1:0]    mem_wdata_q, mem_wdata_d;
  logic [DW-1:0] delay_q, delay_d;
  logic [7:0]    lfsr;
  logic          acked;

  sea_battle_lfsr8 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .en   (state_q != ST_IDLE),
    .lfsr (lfsr)
  );

  assign acked = mem_req_q && mem_ack;

  // Next-state, cursor, scoring and RAM request logic.
  always_comb begin
    state_d       = state_q;
    cursor_x_d    = cursor_x_q;
    cursor_y_d    = cursor_y_q;
    turn_d        = turn_q;
    game_over_d   = game_over_q;
    winner_d      = winner_q;
    player_hits_d = player_hits_q;
    cpu_hits_d    = cpu_hits_q;
    mem_req_d     = mem_req_q;
    mem_we_d      = mem_we_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    delay_d       = delay_q;

    case (state_q)
      ST_IDLE, ST_OVER: begin
        if (start) begin
          player_hits_d = '0;
          cpu_hits_d    = '0;
          cursor_x_d    = '0;
          cursor_y_d    = '0;
          turn_d        = 1'b0;
          game_over_d   = 1'b0;
          winner_d      = 1'b0;
          state_d       = ST_P_WAIT;
        end
      end

      ST_P_WAIT: begin
        if (key_valid) begin
          case (key_code)
            KEY_UP:    if (cursor_y_q != 4'd0)     cursor_y_d = cursor_y_q - 4'd1;
            KEY_DOWN:  if (cursor_y_q != GRID_MAX) cursor_y_d = cursor_y_q + 4'd1;
            KEY_LEFT:  if (cursor_x_q != 4'd0)     cursor_x_d = cursor_x_q - 4'd1;
            KEY_RIGHT: if (cursor_x_q != GRID_MAX) cursor_x_d = cursor_x_q + 4'd1;
            KEY_FIRE: begin
              mem_req_d  = 1'b1;
              mem_we_d   = 1'b0;
              mem_addr_d = {BOARD_ENEMY, cell_index(cursor_y_q, cursor_x_q)};
              state_d    = ST_P_READ;
            end
            default: ;
          endcase
        end
      end

      ST_P_READ: begin
        if (acked) begin
          mem_req_d = 1'b0;
          case (mem_rdata)
            CELL_EMPTY: begin mem_wdata_d = CELL_MISS; state_d = ST_P_WRITE; end
            CELL_SHIP:  begin mem_wdata_d = CELL_HIT;  state_d = ST_P_WRITE; end
            default:    state_d = ST_P_WAIT;
          endcase
        end
      end

      // Write phases enter with mem_req low, so the first cycle issues the write
      // and guarantees the idle cycle between read and write.
      ST_P_WRITE: begin
        if (!mem_req_q) begin
          mem_req_d = 1'b1;
          mem_we_d  = 1'b1;
        end else if (mem_ack) begin
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          if (mem_wdata_q == CELL_HIT) begin
            player_hits_d = player_hits_q + 5'd1;
            if (player_hits_d == SHIPS_L) begin
              game_over_d = 1'b1;
              winner_d    = 1'b0;
              state_d     = ST_OVER;
            end else begin
              state_d = ST_P_WAIT;
            end
          end else begin
            turn_d  = 1'b1;
            delay_d = '0;
            state_d = ST_CPU_THINK;
          end
        end
      end

      ST_CPU_THINK: begin
        if (delay_q == DELAY_L) begin
          state_d = ST_CPU_PICK;
        end else begin
          delay_d = delay_q + 1'b1;
        end
      end

      ST_CPU_PICK: begin
        if (lfsr[3:0] <= GRID_MAX && lfsr[7:4] <= GRID_MAX) begin
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = {BOARD_PLAYER, cell_index(lfsr[7:4], lfsr[3:0])};
          state_d    = ST_C_READ;
        end
      end

      ST_C_READ: begin
        if (acked) begin
          mem_req_d = 1'b0;
          case (mem_rdata)
            CELL_EMPTY: begin mem_wdata_d = CELL_MISS; state_d = ST_C_WRITE; end
            CELL_SHIP:  begin mem_wdata_d = CELL_HIT;  state_d = ST_C_WRITE; end
            default:    state_d = ST_CPU_PICK;
          endcase
        end
      end

      ST_C_WRITE: begin
        if (!mem_req_q) begin
          mem_req_d = 1'b1;
          mem_we_d  = 1'b1;
        end else if (mem_ack) begin
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          if (mem_wdata_q == CELL_HIT) begin
            cpu_hits_d = cpu_hits_q + 5'd1;
            if (cpu_hits_d == SHIPS_L) begin
              game_over_d = 1'b1;
              winner_d    = 1'b1;
              state_d     = ST_OVER;
            end else begin
              delay_d = '0;
              state_d = ST_CPU_THINK;
            end
          end else begin
            turn_d  = 1'b0;
            state_d = ST_P_WAIT;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset abandons any outstanding RAM request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      cursor_x_q    <= '0;
      cursor_y_q    <= '0;
      turn_q        <= 1'b0;
      game_over_q   <= 1'b0;
      winner_q      <= 1'b0;
      player_hits_q <= '0;
      cpu_hits_q    <= '0;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      delay_q       <= '0;
    end else begin
      state_q       <= state_d;
      cursor_x_q    <= cursor_x_d;
      cursor_y_q    <= cursor_y_d;
      turn_q        <= turn_d;
      game_over_q   <= game_over_d;
      winner_q      <= winner_d;
      player_hits_q <= player_hits_d;
      cpu_hits_q    <= cpu_hits_d;
      mem_req_q     <= mem_req_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      delay_q       <= delay_d;
    end
  end

  assign cursor_x    = cursor_x_q;
  assign cursor_y    = cursor_y_q;
  assign turn        = turn_q;
  assign game_over   = game_over_q;
  assign winner      = winner_q;
  assign player_hits = player_hits_q;
  assign cpu_hits    = cpu_hits_q;
  assign mem_req     = mem_req_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;

endmodule

// File: tb/tb_sea_battle_turn_ctrl.sv
// Directed bench for sea_battle_turn_ctrl with a latency-programmable board RAM model.
module tb_sea_battle_turn_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       key_valid;
  logic [2:0] key_code;
  logic [3:0] cursor_x, cursor_y;
  logic       turn, game_over, winner;
  logic [4:0] player_hits, cpu_hits;
  logic       mem_req, mem_we;
  logic [7:0] mem_addr;
  logic [1:0] mem_wdata;
  logic [1:0] mem_rdata;
  logic       mem_ack;

  sea_battle_turn_ctrl #(
    .SHIP_CELLS (2),
    .CPU_DELAY  (4),
    .LFSR_SEED  (8'hA5)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .key_valid   (key_valid),
    .key_code    (key_code),
    .cursor_x    (cursor_x),
    .cursor_y    (cursor_y),
    .turn        (turn),
    .game_over   (game_over),
    .winner      (winner),
    .player_hits (player_hits),
    .cpu_hits    (cpu_hits),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_ack     (mem_ack)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Board RAM model: ack after lat+1 cycles of a seen request, one-cycle ack.
  logic [1:0]  ram [256];
  int unsigned lat;
  int unsigned lat_cnt;
  int unsigned rd_count, wr_count, wr_ack_cyc;
  logic [7:0]  last_rd_addr, last_wr_addr;
  logic [1:0]  last_wr_data;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_ack      <= 1'b0;
      mem_rdata    <= 2'd0;
      lat_cnt      <= 0;
      rd_count     <= 0;
      wr_count     <= 0;
      wr_ack_cyc   <= 0;
      last_rd_addr <= 8'd0;
      last_wr_addr <= 8'd0;
      last_wr_data <= 2'd0;
      // board 0: every cell already missed except index 55
      for (int i = 0; i < 256; i++) ram[i] <= (i < 128 && i != 55) ? 2'd2 : 2'd0;
      ram[8'h8C] <= 2'd1;
      ram[8'h8D] <= 2'd2;
      ram[8'h94] <= 2'd1;
    end else begin
      mem_ack <= 1'b0;
      if (mem_req && !mem_ack) begin
        if (lat_cnt >= lat) begin
          mem_ack   <= 1'b1;
          mem_rdata <= ram[mem_addr];
          lat_cnt   <= 0;
          if (mem_we) begin
            ram[mem_addr] <= mem_wdata;
            wr_count      <= wr_count + 1;
            last_wr_addr  <= mem_addr;
            last_wr_data  <= mem_wdata;
            wr_ack_cyc    <= cyc;
          end else begin
            rd_count     <= rd_count + 1;
            last_rd_addr <= mem_addr;
          end
        end else begin
          lat_cnt <= lat_cnt + 1;
        end
      end
    end
  end

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic press(input logic [2:0] code);
    @(negedge clk);
    key_valid = 1'b1;
    key_code  = code;
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  int unsigned r0, w0, req_cyc;

  initial begin
    rst = 1'b1; start = 1'b0; key_valid = 1'b0; key_code = 3'd0; lat = 0;
    run(3);
    check("rst_cursor_x", 32'(cursor_x), 0);
    check("rst_cursor_y", 32'(cursor_y), 0);
    check("rst_turn", 32'(turn), 0);
    check("rst_game_over", 32'(game_over), 0);
    check("rst_mem_req", 32'(mem_req), 0);
    check("rst_player_hits", 32'(player_hits), 0);
    rst = 1'b0;
    run(1);

    press(3'd3);
    check("idle_key_ignored", 32'(cursor_x), 0);

    pulse_start();
    repeat (12) press(3'd3);
    repeat (3) press(3'd1);
    check("sat_right_x", 32'(cursor_x), 9);
    check("down_y", 32'(cursor_y), 3);
    repeat (10) press(3'd2);
    check("sat_left_x", 32'(cursor_x), 0);
    press(3'd5);
    check("ignored_key_x", 32'(cursor_x), 0);
    check("ignored_key_y", 32'(cursor_y), 3);
    repeat (2) press(3'd3);
    repeat (2) press(3'd0);
    check("cursor_2_1_x", 32'(cursor_x), 2);
    check("cursor_2_1_y", 32'(cursor_y), 1);

    // player hit at board1[12]
    r0 = rd_count; w0 = wr_count;
    press(3'd4);
    run(12);
    check("hit_reads", rd_count - r0, 1);
    check("hit_rd_addr", 32'(last_rd_addr), 32'h8C);
    check("hit_writes", wr_count - w0, 1);
    check("hit_wr_addr", 32'(last_wr_addr), 32'h8C);
    check("hit_wr_data", 32'(last_wr_data), 3);
    check("hit_player_hits", 32'(player_hits), 1);
    check("hit_turn", 32'(turn), 0);

    // already-shot cell board1[13]
    press(3'd3);
    r0 = rd_count; w0 = wr_count;
    press(3'd4);
    run(12);
    check("shot_reads", rd_count - r0, 1);
    check("shot_writes", wr_count - w0, 0);
    check("shot_turn", 32'(turn), 0);
    press(3'd3);
    check("shot_back_in_wait", 32'(cursor_x), 4);

    // player miss at board1[14] hands over to the computer
    press(3'd4);
    for (int i = 0; i < 50 && !turn; i++) @(negedge clk);
    check("miss_turn", 32'(turn), 1);
    check("miss_wr_addr", 32'(last_wr_addr), 32'h8E);
    check("miss_wr_data", 32'(last_wr_data), 2);
    // 3 + 253 = 256 cycles per read makes each computer pick advance the
    // 255-state LFSR by exactly one step, so every state is eventually tried.
    lat = 253;
    for (int i = 0; i < 200 && !mem_req; i++) @(negedge clk);
    req_cyc = cyc;
    check("cpu_req_seen", 32'(mem_req), 1);
    check("cpu_delay_ok", 32'(req_cyc - wr_ack_cyc >= 5), 1);
    check("cpu_board0", 32'(mem_addr[7]), 0);
    check("cpu_idx_range", 32'(mem_addr[6:0] < 7'd100), 1);
    check("cpu_read_we", 32'(mem_we), 0);
    for (int i = 0; i < 40000 && turn; i++) @(negedge clk);
    check("cpu_turn_back", 32'(turn), 0);
    check("cpu_rd_addr", 32'(last_rd_addr), 32'h37);
    check("cpu_wr_addr", 32'(last_wr_addr), 32'h37);
    check("cpu_wr_data", 32'(last_wr_data), 2);
    check("cpu_hits", 32'(cpu_hits), 0);
    lat = 0;

    // second player hit at board1[20] wins with SHIP_CELLS=2
    repeat (4) press(3'd2);
    press(3'd1);
    press(3'd4);
    run(12);
    check("over_game_over", 32'(game_over), 1);
    check("over_winner", 32'(winner), 0);
    check("over_player_hits", 32'(player_hits), 2);
    r0 = rd_count;
    press(3'd3);
    press(3'd1);
    press(3'd4);
    run(6);
    check("over_keys_x", 32'(cursor_x), 0);
    check("over_keys_y", 32'(cursor_y), 2);
    check("over_no_access", rd_count - r0, 0);

    pulse_start();
    check("restart_game_over", 32'(game_over), 0);
    check("restart_player_hits", 32'(player_hits), 0);
    check("restart_cpu_hits", 32'(cpu_hits), 0);
    check("restart_cursor_y", 32'(cursor_y), 0);

    // reset while a slow access is outstanding
    lat = 3;
    press(3'd4);
    for (int i = 0; i < 20 && !mem_req; i++) @(negedge clk);
    check("abandon_req_seen", 32'(mem_req), 1);
    #2 rst = 1'b1;
    #1;
    check("abandon_mem_req", 32'(mem_req), 0);
    check("abandon_mem_addr", 32'(mem_addr), 0);
    check("abandon_mem_we", 32'(mem_we), 0);
    check("abandon_mem_wdata", 32'(mem_wdata), 0);
    check("abandon_turn", 32'(turn), 0);
    check("abandon_game_over", 32'(game_over), 0);
    check("abandon_cursor", 32'({cursor_x, cursor_y}), 0);
    run(2);
    rst = 1'b0;
    run(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sea_battle_turn_ctrl.md
Name: sea_battle_turn_ctrl

Overview:
Game sequencer for sea_battle. Takes decoded keyboard events, moves the aiming cursor over the enemy grid, and fires player shots. It generates computer shots from an LFSR and updates both 10x10 boards through a single req/ack port into the shared board RAM. It sits between the PS/2 key decoder and the board RAM; the VGA renderer reads cursor, turn and hit counters.

Parameters:
SHIP_CELLS, 20, ship cells per board; reaching this hit count wins
CPU_DELAY, 25000000, clk cycles of CPU_THINK before each computer shot (0 = immediate)
LFSR_SEED, 8'hA5, non-zero reset value of the 8-bit LFSR

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
start  in  1  one-cycle pulse, begins a new game
key_valid  in  1  one-cycle strobe, key_code valid
key_code  in  3  0 up, 1 down, 2 left, 3 right, 4 fire, 5-7 ignored
cursor_x  out  4  player aim column, 0..9
cursor_y  out  4  player aim row, 0..9
turn  out  1  0 player, 1 computer
game_over  out  1  high in OVER
winner  out  1  valid when game_over: 0 player, 1 computer
player_hits  out  5  hits scored by player
cpu_hits  out  5  hits scored by computer
mem_req  out  1  RAM access request
mem_we  out  1  1 write, 0 read
mem_addr  out  8  {board, 7-bit index y*10+x}; board 0 = player's own, 1 = enemy
mem_wdata  out  2  cell code to write
mem_rdata  in  2  cell code, valid in the ack cycle
mem_ack  in  1  access complete

Behaviour:
- Cell codes: 0 empty, 1 ship, 2 miss, 3 hit.
- Reset: state IDLE, cursor 0/0, turn 0, game_over 0, winner 0, hit counters 0, mem_req 0, mem_we 0, mem_addr 0, mem_wdata 0, LFSR=LFSR_SEED, delay counter 0.
- LFSR: x^8+x^6+x^5+x^4+1, steps every clk in every state except IDLE.
- Handshake: addr/we/wdata are registered with mem_req. All are held stable while mem_req=1. mem_req drops in the cycle after mem_ack is sampled high. Minimum one cycle between accesses; no back-to-back requests.
- States:
  - IDLE: start -> clear counters, cursor 0/0, turn 0 -> P_WAIT.
  - P_WAIT: handle key_valid.
    - up/down/left/right move the cursor by 1 and saturate at 0 and 9 (no wrap).
    - fire -> P_READ at board 1, index cursor_y*10+cursor_x.
    - Any key that is not a move or fire is ignored.
  - P_READ: on ack, code 0 -> P_WRITE with code 2; code 1 -> P_WRITE with code 3; code 2/3 (already shot) -> P_WAIT with no write and no turn change.
  - P_WRITE: on ack:
    - If it was a hit, player_hits+1. If that reaches SHIP_CELLS -> OVER with winner 0. Otherwise -> P_WAIT; the player keeps the turn.
    - If it was a miss, turn<=1 and the delay counter is cleared -> CPU_THINK.
  - CPU_THINK: count CPU_DELAY cycles, then -> CPU_PICK.
  - CPU_PICK: take x=lfsr[3:0], y=lfsr[7:4]. If x>9 or y>9, retry next cycle; else -> C_READ at board 0.
  - C_READ: on ack, code 0 -> C_WRITE with code 2; code 1 -> C_WRITE with code 3; code 2/3 -> CPU_PICK (retry with a new LFSR value).
  - C_WRITE: on ack:
    - If it was a hit, cpu_hits+1. If that reaches SHIP_CELLS -> OVER with winner 1. Otherwise -> CPU_THINK; the computer keeps the turn.
    - If it was a miss, turn<=0 -> P_WAIT.
  - OVER: game_over=1; outputs frozen. start -> same init as in IDLE.
- key_valid outside P_WAIT is dropped, not queued.
- start outside IDLE/OVER is ignored.
- Reset mid-access forces mem_req low immediately (async); the RAM must tolerate an abandoned request.
- Hit counters are 5 bits and never exceed SHIP_CELLS.

Decomposition:
- Package sea_battle_pkg: cell code constants (CELL_EMPTY/SHIP/MISS/HIT), key code constants, GRID_N=10, board-select constants, state enum.
- One sub-module: sea_battle_lfsr8 (seed parameter, enable input, 8-bit output).
- Index arithmetic y*10+x is computed as (y<<3)+(y<<1)+x, 7 bits.

Test Plan:
- Reset then start; key right x12 and down x3 -> cursor 9/3 (saturated); key left at x=0 keeps 0.
- Cursor 2/1, RAM board1[12]=1, fire -> read addr 8'h8C, then write addr 8'h8C with data 3; player_hits=1; turn stays 0.
- Fire at a cell holding 2 -> one read only, no write, state stays P_WAIT, turn 0.
- Player miss with CPU_DELAY=4 -> turn=1; first computer mem_req no earlier than 5 cycles after the miss write ack; address board bit 0 with index <100.
- Board0 all cells code 2 except index 55=0: the computer retries until addr 8'h37, then writes 2; turn returns to 0.
- SHIP_CELLS=2, player hits twice -> game_over=1, winner 0; keys ignored; start restarts with counters 0.
- Assert rst while mem_req=1 with a 3-cycle-latency ack model -> mem_req 0 in the same cycle; all outputs at reset values.
